// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and decoder state encoding.
// Edge positions assume the generator registers its syncs and the decoder samples them twice.
package vga_timing_pkg;

  localparam int H_DISPLAY     = 640;
  localparam int H_FRONT_PORCH = 16;
  localparam int H_SYNC_PULSE  = 96;
  localparam int H_TOTAL       = 800;
  localparam int V_DISPLAY     = 480;
  localparam int V_FRONT_PORCH = 10;
  localparam int V_SYNC_PULSE  = 2;
  localparam int V_TOTAL       = 525;

  // Generator output register plus the decoder's two sample flops put the edge at 658.
  localparam int H_EDGE_POS  = H_DISPLAY + H_FRONT_PORCH + 2;
  localparam int V_EDGE_POS  = V_DISPLAY + V_FRONT_PORCH;
  localparam int LOCK_FRAMES = 2;
  localparam int TIMEOUT     = 2 * H_TOTAL;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } dec_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop sampler for an active-low sync input; flags the assertion (high-to-low) edge.
module sync_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic sync_in,
  output logic assert_edge
);

  logic s_q;
  logic s_qq;

  // Sample stage; resets to the deasserted level so reset never fakes an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_q  <= 1'b1;
      s_qq <= 1'b1;
    end else begin
      s_q  <= sync_in;
      s_qq <= s_q;
    end
  end

  assign assert_edge = !s_q && s_qq;

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers pixel position from incoming hsync/vsync and tracks lock on line/frame periods.
// Optional: define VGA_DEC_FRAME_CNT_EN to add the frame_count output.
module vga_sync_decoder #(
  parameter int H_DISPLAY   = vga_timing_pkg::H_DISPLAY,
  parameter int H_TOTAL     = vga_timing_pkg::H_TOTAL,
  parameter int H_EDGE_POS  = vga_timing_pkg::H_EDGE_POS,
  parameter int V_DISPLAY   = vga_timing_pkg::V_DISPLAY,
  parameter int V_TOTAL     = vga_timing_pkg::V_TOTAL,
  parameter int V_EDGE_POS  = vga_timing_pkg::V_EDGE_POS,
  parameter int LOCK_FRAMES = vga_timing_pkg::LOCK_FRAMES,
  parameter int TIMEOUT     = vga_timing_pkg::TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hsync_in,
  input  logic        vsync_in,
  output logic [9:0]  hpos,
  output logic [9:0]  vpos,
  output logic        display_on,
  output logic        locked,
  output logic        sync_err
`ifdef VGA_DEC_FRAME_CNT_EN
  ,
  output logic [15:0] frame_count
`endif
);

  import vga_timing_pkg::*;

  localparam logic [9:0]  H_LAST      = 10'(H_TOTAL - 1);
  localparam logic [9:0]  H_RELOAD    = (H_EDGE_POS + 1 >= H_TOTAL) ? 10'd0 : 10'(H_EDGE_POS + 1);
  localparam logic [9:0]  H_ACT       = 10'(H_DISPLAY);
  localparam logic [9:0]  V_LAST      = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_LOAD      = 10'(V_EDGE_POS);
  localparam logic [9:0]  V_ACT       = 10'(V_DISPLAY);
  localparam logic [11:0] LINE_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] TO_LAST     = 12'(TIMEOUT - 1);
  localparam logic [11:0] FRAME_LINES = 12'(V_TOTAL);
  localparam logic [3:0]  GOOD_LAST   = 4'(LOCK_FRAMES - 1);

  logic        hs_edge, vs_edge;
  logic [9:0]  h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [11:0] period_q, period_d;
  logic [10:0] frame_cnt_q, frame_cnt_d;
  logic        line_valid_q, line_valid_d;
  dec_state_e  state_q, state_d;
  logic [3:0]  good_cnt_q, good_cnt_d;
  logic        locked_q, locked_d;
  logic        sync_err_q, sync_err_d;
  logic [11:0] frame_lines_s;
  logic        frame_valid_s, bad_line_s, timeout_s, bad_frame_s, good_frame_s, fail_s;

  sync_edge_detect u_hs_edge (.clk(clk), .reset(reset), .sync_in(hsync_in), .assert_edge(hs_edge));
  sync_edge_detect u_vs_edge (.clk(clk), .reset(reset), .sync_in(vsync_in), .assert_edge(vs_edge));

  // Position counters and the line/frame period measurements.
  always_comb begin
    h_cnt_d = h_cnt_q;
    if (hs_edge) begin
      h_cnt_d = H_RELOAD;
    end else if (h_cnt_q == H_LAST) begin
      h_cnt_d = 10'd0;
    end else begin
      h_cnt_d = h_cnt_q + 10'd1;
    end

    v_cnt_d = v_cnt_q;
    if (vs_edge) begin
      v_cnt_d = V_LOAD;
    end else if (h_cnt_d == 10'd0) begin
      v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
    end else begin
      v_cnt_d = v_cnt_q;
    end

    period_d = period_q;
    if (hs_edge) begin
      period_d = 12'd0;
    end else if (period_q != 12'hFFF) begin
      period_d = period_q + 12'd1;
    end else begin
      period_d = period_q;
    end

    // A coincident hsync edge still belongs to the frame that is closing.
    frame_lines_s = {1'b0, frame_cnt_q} + {11'd0, hs_edge};
    frame_cnt_d   = frame_cnt_q;
    if (vs_edge) begin
      frame_cnt_d = 11'd0;
    end else if (hs_edge && (frame_cnt_q != 11'h7FF)) begin
      frame_cnt_d = frame_cnt_q + 11'd1;
    end else begin
      frame_cnt_d = frame_cnt_q;
    end
  end

  // Period checks and the SEARCH/ACQUIRE/LOCKED tracker.
  always_comb begin
    frame_valid_s = (state_q != SEARCH);
    bad_line_s    = hs_edge && line_valid_q && (period_q != LINE_LAST);
    // Timeout needs a reference edge, so an idle input does not pulse sync_err forever.
    timeout_s     = !hs_edge && line_valid_q && (period_q == TO_LAST);
    bad_frame_s   = vs_edge && frame_valid_s && (frame_lines_s != FRAME_LINES);
    good_frame_s  = vs_edge && frame_valid_s && (frame_lines_s == FRAME_LINES);
    fail_s        = bad_line_s || timeout_s || bad_frame_s;

    state_d      = state_q;
    good_cnt_d   = good_cnt_q;
    line_valid_d = line_valid_q;
    if (fail_s) begin
      state_d      = SEARCH;
      good_cnt_d   = 4'd0;
      line_valid_d = 1'b0;
    end else begin
      line_valid_d = line_valid_q || hs_edge;
      case (state_q)
        SEARCH: begin
          if (vs_edge) begin
            state_d    = ACQUIRE;
            good_cnt_d = 4'd0;
          end else begin
            state_d = SEARCH;
          end
        end
        ACQUIRE: begin
          if (good_frame_s) begin
            good_cnt_d = good_cnt_q + 4'd1;
            state_d    = (good_cnt_q == GOOD_LAST) ? LOCKED : ACQUIRE;
          end else begin
            state_d = ACQUIRE;
          end
        end
        LOCKED:  state_d = LOCKED;
        default: state_d = SEARCH;
      endcase
    end

    locked_d   = (state_d == LOCKED);
    sync_err_d = fail_s;
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt_q      <= 10'd0;
      v_cnt_q      <= 10'd0;
      period_q     <= 12'd0;
      frame_cnt_q  <= 11'd0;
      line_valid_q <= 1'b0;
      state_q      <= SEARCH;
      good_cnt_q   <= 4'd0;
      locked_q     <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      h_cnt_q      <= h_cnt_d;
      v_cnt_q      <= v_cnt_d;
      period_q     <= period_d;
      frame_cnt_q  <= frame_cnt_d;
      line_valid_q <= line_valid_d;
      state_q      <= state_d;
      good_cnt_q   <= good_cnt_d;
      locked_q     <= locked_d;
      sync_err_q   <= sync_err_d;
    end
  end

`ifdef VGA_DEC_FRAME_CNT_EN
  logic [15:0] frame_count_q, frame_count_d;

  // Good frames seen while already locked; wraps naturally at 16 bits.
  always_comb begin
    if (good_frame_s && !fail_s && (state_q == LOCKED)) begin
      frame_count_d = frame_count_q + 16'd1;
    end else begin
      frame_count_d = frame_count_q;
    end
  end

  // Frame counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_count_q <= 16'd0;
    end else begin
      frame_count_q <= frame_count_d;
    end
  end

  assign frame_count = frame_count_q;
`endif

  assign hpos       = h_cnt_q;
  assign vpos       = v_cnt_q;
  assign locked     = locked_q;
  assign sync_err   = sync_err_q;
  assign display_on = locked_q && (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);

endmodule
